// File: rtl/spi_rdid_pkg.sv
// Shared types and constants for the SPI flash RDID reader.
package spi_rdid_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    localparam logic [7:0] CMD_RDID   = 8'h9F;
    localparam int         ID_BITS    = 24;
    localparam int         TOTAL_BITS = 32;

    // A manufacturer byte of all zeros or all ones means the bus is floating or stuck.
    function automatic logic mfr_plausible(input logic [7:0] mfr);
        return (mfr != 8'h00) && (mfr != 8'hFF);
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Mode-0 SCK generator: CLK_DIV cycles per half period, with strobes marking the end of each phase.
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    input  logic park_i,
    output logic sck_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int                CNT_W = $clog2(CLK_DIV) + 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             sck_q;
    logic             phase_end;

    // rise_tick marks the end of a low phase even when park_i keeps SCK from actually rising.
    assign phase_end   = en_i && (cnt_q == LAST);
    assign rise_tick_o = phase_end && !sck_q;
    assign fall_tick_o = phase_end && sck_q;
    assign sck_o       = sck_q;

    always_ff @(posedge clk) begin
        if (!reset_n || !en_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else if (phase_end) begin
            cnt_q <= '0;
            sck_q <= sck_q ? 1'b0 : !park_i;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_rdid_reader.sv
// Issues a JEDEC RDID (0x9F) on each button press and holds the 3-byte flash ID.
// Define RDID_JEDEC_CHECK_EN to register a manufacturer-byte plausibility flag on id_ok.
module spi_rdid_reader
    import spi_rdid_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                id_valid,
    output logic [ID_BITS-1:0]  id_data,
    output logic                id_ok,
    output logic                spi_cs_n,
    output logic                spi_sck,
    output logic                spi_mosi,
    input  logic                spi_miso
);

    localparam logic [5:0] LAST_BIT     = 6'(TOTAL_BITS - 1);
    localparam logic [5:0] FIRST_ID_BIT = 6'(TOTAL_BITS - ID_BITS);

    state_t              state_q;
    logic                prev_start_q;
    logic [5:0]          bit_cnt_q;
    logic [7:0]          cmd_q;
    logic [ID_BITS-1:0]  shreg_q;
    logic [ID_BITS-1:0]  id_data_q;
    logic                id_valid_q;
    logic                done_q;
    logic                busy_q;
    logic                cs_n_q;
    logic                mosi_q;

    logic sck_en;
    logic sck_park;
    logic rise_tick;
    logic fall_tick;

    // SCK is parked low during the final low phase of bit 31 and throughout HOLD.
    assign sck_en   = (state_q != IDLE);
    assign sck_park = (state_q == HOLD) || (bit_cnt_q == LAST_BIT);

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .en_i        (sck_en),
        .park_i      (sck_park),
        .sck_o       (spi_sck),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            prev_start_q <= 1'b1;
            bit_cnt_q    <= '0;
            cmd_q        <= '0;
            shreg_q      <= '0;
            id_data_q    <= '0;
            id_valid_q   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            mosi_q       <= 1'b0;
        end else begin
            prev_start_q <= start;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !prev_start_q) begin
                        state_q   <= SETUP;
                        cs_n_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        cmd_q     <= CMD_RDID;
                        mosi_q    <= CMD_RDID[7];
                    end
                end
                SETUP: begin
                    if (rise_tick) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // cmd_q back-fills with zeros, so MOSI stays low once the opcode is out.
                    if (fall_tick) begin
                        mosi_q <= cmd_q[6];
                        cmd_q  <= {cmd_q[6:0], 1'b0};
                        if (bit_cnt_q >= FIRST_ID_BIT) begin
                            shreg_q <= {shreg_q[ID_BITS-2:0], spi_miso};
                        end
                    end
                    if (rise_tick) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= HOLD;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                        end
                    end
                end
                HOLD: begin
                    if (rise_tick) begin
                        state_q    <= IDLE;
                        cs_n_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        id_valid_q <= 1'b1;
                        id_data_q  <= shreg_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef RDID_JEDEC_CHECK_EN
    logic id_ok_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            id_ok_q <= 1'b0;
        end else if (state_q == HOLD && rise_tick) begin
            id_ok_q <= mfr_plausible(shreg_q[ID_BITS-1 -: 8]);
        end
    end

    assign id_ok = id_ok_q;
`else
    assign id_ok = id_valid_q;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign id_valid = id_valid_q;
    assign id_data  = id_data_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_rdid_reader.sv
// Scoreboard bench for spi_rdid_reader: slave model returns a programmed ID, a CLK_DIV=1 instance runs alongside.
module tb_spi_rdid_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RDID_JEDEC_CHECK_EN
    localparam logic EXP_OK_STUCK = 1'b0;
`else
    localparam logic EXP_OK_STUCK = 1'b1;
`endif

    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, id_valid, id_ok, spi_cs_n, spi_sck, spi_mosi;
    logic        spi_miso = 1'b0;
    logic [23:0] id_data;

    logic        startF = 1'b0;
    logic        busyF, doneF, id_validF, id_okF, spi_cs_nF, spi_sckF, spi_mosiF;
    logic [23:0] id_dataF;

    spi_rdid_reader #(.CLK_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .id_valid(id_valid), .id_data(id_data), .id_ok(id_ok), .spi_cs_n(spi_cs_n),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_rdid_reader #(.CLK_DIV(1)) dutF (
        .clk(clk), .reset_n(reset_n), .start(startF), .busy(busyF), .done(doneF),
        .id_valid(id_validF), .id_data(id_dataF), .id_ok(id_okF), .spi_cs_n(spi_cs_nF),
        .spi_sck(spi_sckF), .spi_mosi(spi_mosiF), .spi_miso(1'b1)
    );

    int checks = 0;
    int passed = 0;
    logic [23:0] expQ[$];
    logic [23:0] expId;
    logic [23:0] slaveId = 24'h0;

    // Monitor counters only ever increase; tasks snapshot a base and compare differences.
    int sckRises = 0, sckBase = 0;
    int strayCount = 0, strayBase = 0;
    int lowTotal = 0, lowBase = 0;
    int lowTotalF = 0, lowBaseF = 0;
    int doneCount = 0, doneCountF = 0;
    int csFalls = 0;
    logic [7:0] cmdSeen = 8'h00;

    always @(posedge spi_sck) begin
        int idx;
        idx = sckRises - sckBase;
        if (idx < 8) cmdSeen[7-idx] = spi_mosi;
        else if (spi_mosi !== 1'b0) strayCount++;
        sckRises++;
    end

    // Flash model: drives the next ID bit after each SCK fall, first ID bit after the opcode.
    always @(negedge spi_sck) begin
        int idx;
        idx = sckRises - sckBase;
        if (idx >= 8 && idx < 32) spi_miso = slaveId[31-idx];
        else spi_miso = 1'b0;
    end

    always @(negedge spi_cs_n) csFalls++;

    always @(posedge clk) begin
        if (spi_cs_n === 1'b0) lowTotal++;
        if (spi_cs_nF === 1'b0) lowTotalF++;
        if (done === 1'b1) doneCount++;
        if (doneF === 1'b1) doneCountF++;
    end

    task automatic applyStimulus(input logic [23:0] id, input bit expectDone);
        @(negedge clk);
        slaveId = id;
        if (expectDone) expQ.push_back(id);
        sckBase = sckRises;
        lowBase = lowTotal;
        strayBase = strayCount;
        start = 1'b1;
    endtask

    task automatic waitDone(input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start = 1'b0;
        startF = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%0b want=0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done got=%0b want=0", done); else passed++;
        checks++; if (id_valid !== 1'b0) $display("[TB] FAIL reset_id_valid got=%0b want=0", id_valid); else passed++;
        checks++; if (id_data !== 24'h0) $display("[TB] FAIL reset_id_data got=%h want=000000", id_data); else passed++;
        checks++; if (id_ok !== 1'b0) $display("[TB] FAIL reset_id_ok got=%0b want=0", id_ok); else passed++;
        checks++; if (spi_cs_n !== 1'b1) $display("[TB] FAIL reset_cs_n got=%0b want=1", spi_cs_n); else passed++;
        checks++; if (spi_sck !== 1'b0) $display("[TB] FAIL reset_sck got=%0b want=0", spi_sck); else passed++;
        checks++; if (spi_mosi !== 1'b0) $display("[TB] FAIL reset_mosi got=%0b want=0", spi_mosi); else passed++;
        checks++; if (spi_cs_nF !== 1'b1) $display("[TB] FAIL reset_cs_n_div1 got=%0b want=1", spi_cs_nF); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_read;
        bit seen;
        int doneBase;
        doneBase = doneCount;
        applyStimulus(24'hEF4018, 1);
        @(posedge clk);
        #1;
        checks++; if (spi_cs_n !== 1'b0) $display("[TB] FAIL single_t1_cs_n got=%0b want=0", spi_cs_n); else passed++;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL single_t1_busy got=%0b want=1", busy); else passed++;
        @(negedge clk);
        start = 1'b0;
        waitDone(1000, seen);
        checks++; if (!seen) $display("[TB] FAIL single_done_timeout got=none want=done pulse"); else passed++;
        expId = expQ.pop_front();
        checks++; if (id_data !== expId) $display("[TB] FAIL single_id_data got=%h want=%h", id_data, expId); else passed++;
        checks++; if (id_valid !== 1'b1) $display("[TB] FAIL single_id_valid got=%0b want=1", id_valid); else passed++;
        checks++; if (id_ok !== 1'b1) $display("[TB] FAIL single_id_ok got=%0b want=1", id_ok); else passed++;
        checks++; if (spi_cs_n !== 1'b1) $display("[TB] FAIL single_cs_n_at_done got=%0b want=1", spi_cs_n); else passed++;
        checks++; if (lowTotal - lowBase != 264) $display("[TB] FAIL single_cs_low_cycles got=%0d want=264", lowTotal - lowBase); else passed++;
        checks++; if (cmdSeen !== 8'h9F) $display("[TB] FAIL single_mosi_cmd got=%h want=9f", cmdSeen); else passed++;
        checks++; if (strayCount != strayBase) $display("[TB] FAIL single_mosi_idle got=%0d want=0", strayCount - strayBase); else passed++;
        checks++; if (sckRises - sckBase != 32) $display("[TB] FAIL single_sck_count got=%0d want=32", sckRises - sckBase); else passed++;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (doneCount - doneBase != 1) $display("[TB] FAIL single_done_pulses got=%0d want=1", doneCount - doneBase); else passed++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL single_done_low got=%0b want=0", done); else passed++;
    endtask

    task automatic test_held_start;
        int doneBase, fallBase;
        doneBase = doneCount;
        fallBase = csFalls;
        applyStimulus(24'h1F8901, 1);
        repeat (2000) @(posedge clk);
        #1;
        checks++; if (doneCount - doneBase != 1) $display("[TB] FAIL held_done_pulses got=%0d want=1", doneCount - doneBase); else passed++;
        checks++; if (csFalls - fallBase != 1) $display("[TB] FAIL held_transactions got=%0d want=1", csFalls - fallBase); else passed++;
        expId = expQ.pop_front();
        checks++; if (id_data !== expId) $display("[TB] FAIL held_id_data got=%h want=%h", id_data, expId); else passed++;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        bit seen;
        int fallBase;
        fallBase = csFalls;
        applyStimulus(24'hEF4018, 1);
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        start = 1'b1;
        repeat (10) @(negedge clk);
        start = 1'b0;
        waitDone(1000, seen);
        checks++; if (!seen) $display("[TB] FAIL b2b_first_done_timeout got=none want=done pulse"); else passed++;
        expId = expQ.pop_front();
        checks++; if (id_data !== expId) $display("[TB] FAIL b2b_first_id got=%h want=%h", id_data, expId); else passed++;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (csFalls - fallBase != 1) $display("[TB] FAIL b2b_busy_edge_dropped got=%0d want=1", csFalls - fallBase); else passed++;
        checks++; if (spi_cs_n !== 1'b1) $display("[TB] FAIL b2b_idle_cs_n got=%0b want=1", spi_cs_n); else passed++;

        applyStimulus(24'hC22016, 1);
        @(negedge clk);
        start = 1'b0;
        waitDone(1000, seen);
        checks++; if (!seen) $display("[TB] FAIL b2b_second_done_timeout got=none want=done pulse"); else passed++;
        expId = expQ.pop_front();
        checks++; if (id_data !== expId) $display("[TB] FAIL b2b_second_id got=%h want=%h", id_data, expId); else passed++;

        applyStimulus(24'hEF4018, 1);
        @(posedge clk);
        #1;
        checks++; if (spi_cs_n !== 1'b0) $display("[TB] FAIL b2b_accept_after_done got=%0b want=0", spi_cs_n); else passed++;
        @(negedge clk);
        start = 1'b0;
        waitDone(1000, seen);
        checks++; if (!seen) $display("[TB] FAIL b2b_third_done_timeout got=none want=done pulse"); else passed++;
        expId = expQ.pop_front();
        checks++; if (id_data !== expId) $display("[TB] FAIL b2b_third_id got=%h want=%h", id_data, expId); else passed++;
    endtask

    task automatic test_reset_held_start;
        int fallBase;
        fallBase = csFalls;
        @(negedge clk);
        reset_n = 1'b0;
        start = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        checks++; if (csFalls != fallBase) $display("[TB] FAIL held_reset_transactions got=%0d want=0", csFalls - fallBase); else passed++;
        checks++; if (spi_cs_n !== 1'b1) $display("[TB] FAIL held_reset_cs_n got=%0b want=1", spi_cs_n); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL held_reset_busy got=%0b want=0", busy); else passed++;
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mid_reset;
        bit seen;
        bit reached;
        applyStimulus(24'hC22016, 1);
        @(negedge clk);
        start = 1'b0;
        waitDone(1000, seen);
        checks++; if (!seen) $display("[TB] FAIL mid_pre_done_timeout got=none want=done pulse"); else passed++;
        expId = expQ.pop_front();
        checks++; if (id_data !== expId) $display("[TB] FAIL mid_pre_id got=%h want=%h", id_data, expId); else passed++;

        applyStimulus(24'hEF4018, 0);
        reached = 0;
        for (int i = 0; i < 1000 && !reached; i++) begin
            @(negedge clk);
            if (sckRises - sckBase >= 16) reached = 1;
        end
        checks++; if (!reached) $display("[TB] FAIL mid_bit15_timeout got=%0d want=16 sck rises", sckRises - sckBase); else passed++;
        reset_n = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (spi_cs_n !== 1'b1) $display("[TB] FAIL mid_cs_n got=%0b want=1", spi_cs_n); else passed++;
        checks++; if (spi_sck !== 1'b0) $display("[TB] FAIL mid_sck got=%0b want=0", spi_sck); else passed++;
        checks++; if (id_valid !== 1'b0) $display("[TB] FAIL mid_id_valid got=%0b want=0", id_valid); else passed++;
        checks++; if (id_data !== 24'h0) $display("[TB] FAIL mid_id_data got=%h want=000000", id_data); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL mid_busy got=%0b want=0", busy); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        applyStimulus(24'hEF4018, 1);
        @(negedge clk);
        start = 1'b0;
        waitDone(1000, seen);
        checks++; if (!seen) $display("[TB] FAIL mid_post_done_timeout got=none want=done pulse"); else passed++;
        expId = expQ.pop_front();
        checks++; if (id_data !== expId) $display("[TB] FAIL mid_post_id got=%h want=%h", id_data, expId); else passed++;
        checks++; if (lowTotal - lowBase != 264) $display("[TB] FAIL mid_post_cs_low got=%0d want=264", lowTotal - lowBase); else passed++;
    endtask

    task automatic test_clk_div1;
        bit seen;
        int doneBase;
        doneBase = doneCountF;
        @(negedge clk);
        lowBaseF = lowTotalF;
        startF = 1'b1;
        @(negedge clk);
        startF = 1'b0;
        seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (doneF === 1'b1) seen = 1;
        end
        checks++; if (!seen) $display("[TB] FAIL div1_done_timeout got=none want=done pulse"); else passed++;
        checks++; if (lowTotalF - lowBaseF != 66) $display("[TB] FAIL div1_cs_low got=%0d want=66", lowTotalF - lowBaseF); else passed++;
        checks++; if (id_dataF !== 24'hFFFFFF) $display("[TB] FAIL div1_id_data got=%h want=ffffff", id_dataF); else passed++;
        checks++; if (id_validF !== 1'b1) $display("[TB] FAIL div1_id_valid got=%0b want=1", id_validF); else passed++;
        checks++; if (id_okF !== EXP_OK_STUCK) $display("[TB] FAIL div1_id_ok got=%0b want=%0b", id_okF, EXP_OK_STUCK); else passed++;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (doneCountF - doneBase != 1) $display("[TB] FAIL div1_done_pulses got=%0d want=1", doneCountF - doneBase); else passed++;
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_held_start;
        test_back_to_back;
        test_reset_held_start;
        test_mid_reset;
        test_clk_div1;
        checks++; if (expQ.size() != 0) $display("[TB] FAIL scoreboard_drained got=%0d want=0", expQ.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/spi_rdid_reader.md
# spi_rdid_reader

Consumes the debounced push-button level and, on each press, issues a JEDEC Read Identification (RDID, 0x9F) command to the on-board SPI flash. It captures the 3-byte ID (manufacturer, memory type, capacity) and holds it for the display/LED stage. It sits directly downstream of the button debouncer, with one transaction per clean press.

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per SCK half-period; legal range ≥ 1.

Ports. One clock; reset is synchronous and active-low.
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  debounced button level; rising edge requests a transaction
- busy  out  1  high while a transaction is in progress (cs_n low)
- done  out  1  one-cycle pulse when the ID has been captured
- id_valid  out  1  high once an ID has been captured since reset
- id_data  out  24  {manufacturer, type, capacity}; byte received first in [23:16]
- id_ok  out  1  ID plausibility flag (see Configuration)
- spi_cs_n  out  1  flash chip select, active low
- spi_sck  out  1  SPI clock, mode 0 (idles low)
- spi_mosi  out  1  command data, MSB first
- spi_miso  in  1  flash data out

## Operation
- Edge detect: a register holds the previous `start`; it resets to 1. A request is accepted when `start`=1, prev=0, and state is IDLE. Edges while busy are dropped, not queued.
- States:
  - IDLE: cs_n=1, sck=0. Exits to SETUP on an accepted request.
  - SETUP: cs_n=0, mosi=bit7 of 0x9F. Lasts CLK_DIV cycles, then goes to SHIFT.
  - SHIFT: runs 32 SCK periods, each CLK_DIV cycles high then CLK_DIV cycles low, then goes to HOLD.
  - HOLD: cs_n=0, sck=0. Lasts CLK_DIV cycles, then goes to IDLE.
- Bits 0–7 shift out 0x9F MSB-first. mosi updates on the clk edge that drives sck low, and is held at 0 for bits 8–31.
- miso is sampled on the clk edge that ends each high phase. Only bits 8–31 shift into a 24-bit shift register, MSB first.
- On the HOLD→IDLE edge: id_data←shift register, id_valid←1, done←1 for one cycle, cs_n←1.
- The bit counter is 6 bits wide and counts 0..31 with no wrap. The half-period counter width is $clog2(CLK_DIV)+1.
- Reset value of every output: busy=0, done=0, id_valid=0, id_data=0, id_ok=0, spi_cs_n=1, spi_sck=0, spi_mosi=0.
- A reset mid-transaction forces all outputs to their reset values on that edge. No partial ID is kept.

## Timing
- The request edge is sampled at cycle T. At T+1, cs_n=0 and busy=1.
- cs_n stays low for exactly 66·CLK_DIV cycles (264 at the default).
- done and the cs_n rise occur on the same edge. id_data and id_valid are stable from that cycle onward.
- The first new request can be accepted in the cycle after done.
- SCK frequency is f_clk/(2·CLK_DIV). SCK has a 50 % duty cycle with no glitches, and all SPI outputs are registered.
- `start` is already synchronised upstream, so no extra synchroniser stage is added.

## Configuration
- RDID_JEDEC_CHECK_EN defined: id_ok is registered alongside id_data. It is 1 iff the manufacturer byte ∉ {0x00, 0xFF} and id_valid=1. This flags a missing or stuck flash.
- Not defined: id_ok = id_valid, and no compare logic is built.

## Structure
- Package spi_rdid_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, HOLD);
  - CMD_RDID = 8'h9F;
  - ID_BITS = 24;
  - TOTAL_BITS = 32.
- Sub-module spi_sck_gen:
  - parameter CLK_DIV;
  - takes an enable and produces sck plus one-cycle rise_tick/fall_tick strobes;
  - the FSM consumes the ticks.

## Test plan
- Reset, then a start pulse, with the slave model returning EF 40 18 → mosi carries 0x9F, id_data=24'hEF4018, one done pulse, cs_n low for 264 cycles.
- Hold start high for 2000 cycles → exactly one transaction and one done pulse.
- Second rising edge during busy → ignored. A press after done with the slave returning C2 20 16 → id_data=24'hC22016.
- start held high through reset and after release → no transaction, cs_n stays 1.
- reset_n low during bit 15 → next cycle cs_n=1, sck=0, id_valid=0, id_data=0. A later press completes normally with EF4018.
- CLK_DIV=1 with miso stuck at 1 → cs_n low for 66 cycles, id_data=24'hFFFFFF. id_ok=0 with RDID_JEDEC_CHECK_EN, id_ok=1 without.
